fetch: RTL and testbench

// - Instruction fetch stage, directly upstream of decode: owns the program counter, reads 16-bit instruction words from memory, buffers them.
// - Presents inst/inst_pc to decode via valid/ready; decode's decode_en is driven from inst_valid & inst_ready by control logic.
// - Supports redirect (jump/branch/reset op) and a fetch_en gate used for HALT.

---
 rtl/fetch.sv | 183 ++++++++++++++++++
 tb/tb_fetch.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch.sv
// -----------------------------------------------------------------------------
// fetch -- instruction fetch stage, directly upstream of decode.
//
// Owns the program counter, issues word-addressed reads of 16-bit instructions
// to memory, buffers returned words and hands them to decode over a
// valid/ready pair. Supports a one-cycle redirect (jump/branch/reset op) and a
// fetch_en gate used for HALT.
//
// Configuration macro: FETCH_PREFETCH_EN
//   defined   : two-entry buffer, a new request may issue in the cycle a word
//               is pushed (1 instruction/cycle with zero-wait memory).
//   undefined : single holding register, next request only once the buffer
//               drains (at most 1 instruction every 2 cycles).
//
// Ports
//   clk            in   1     rising-edge clock
//   rst_n          in   1     asynchronous active-low reset
//   fetch_en       in   1     allow new memory requests
//   redirect       in   1     flush buffer, continue at redirect_addr
//   redirect_addr  in   PC_W  new PC, sampled when redirect=1
//   mem_req        out  1     memory read request
//   mem_addr       out  PC_W  word address, held while waiting for mem_ready
//   mem_ready      in   1     read completes this cycle
//   mem_rdata      in   16    instruction word (valid with mem_ready)
//   inst_valid     out  1     buffer head holds an instruction
//   inst_ready     in   1     decode accepts the head this cycle
//   inst           out  16    head instruction
//   inst_pc        out  PC_W  address of the head instruction
// -----------------------------------------------------------------------------
module fetch #(
  parameter int              PC_W     = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            fetch_en,
  input  logic            redirect,
  input  logic [PC_W-1:0] redirect_addr,
  output logic            mem_req,
  output logic [PC_W-1:0] mem_addr,
  input  logic            mem_ready,
  input  logic [15:0]     mem_rdata,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [15:0]     inst,
  output logic [PC_W-1:0] inst_pc
);

`ifdef FETCH_PREFETCH_EN
  localparam logic [1:0] DEPTH = 2'd2;
`else
  localparam logic [1:0] DEPTH = 2'd1;
`endif

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_REQ   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]      state, state_next;
  logic [PC_W-1:0] pc, pc_next;
  logic [PC_W-1:0] addr_q;
  logic [1:0]      count, count_next;
  logic [15:0]     head_inst;
  logic [PC_W-1:0] head_pc;
`ifdef FETCH_PREFETCH_EN
  logic [15:0]     tail_inst;
  logic [PC_W-1:0] tail_pc;
`endif

  logic push, pop, stall, has_space;

  assign mem_req    = (state != S_IDLE);
  assign mem_addr   = addr_q;
  assign inst_valid = (count != 2'd0);
  assign inst       = head_inst;
  assign inst_pc    = head_pc;

  // A returned word is kept only for a live request that is not being
  // redirected in the same cycle; DRAIN responses are always discarded.
  assign push  = (state == S_REQ) && mem_ready && !redirect;
  assign pop   = inst_valid && inst_ready;
  assign stall = mem_req && !mem_ready;

  // Occupancy after this cycle; redirect wins over push and pop.
  // NOTE: every signal assigned in an always_comb gets a default first so no
  // path through the block can infer a latch.
  always_comb begin
    count_next = count;
    if (redirect) begin
      count_next = 2'd0;
    end else begin
      case ({push, pop})
        2'b10:   count_next = count + 2'd1;
        2'b01:   count_next = count - 2'd1;
        default: count_next = count;
      endcase
    end
  end

  assign has_space = (count_next < DEPTH);

  always_comb begin
    pc_next = pc;
    if (redirect)  pc_next = redirect_addr;
    else if (push) pc_next = pc + PC_W'(1);  // wraps silently at 2^PC_W-1
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (fetch_en && has_space) state_next = S_REQ;
      end
      S_REQ: begin
        if (mem_ready)     state_next = (fetch_en && has_space) ? S_REQ : S_IDLE;
        else if (redirect) state_next = S_DRAIN;
      end
      S_DRAIN: begin
        if (mem_ready) state_next = (fetch_en && has_space) ? S_REQ : S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      pc     <= RESET_PC;
      addr_q <= RESET_PC;
      count  <= 2'd0;
    end else begin
      state <= state_next;
      pc    <= pc_next;
      count <= count_next;
      // The request address only moves when no request is waiting, so it is
      // frozen for the whole handshake (including across a redirect in DRAIN).
      if (!stall) addr_q <= pc_next;
    end
  end

  // Buffer storage. Flushing only clears the count; the head keeps its last
  // value so inst/inst_pc never go X.
  // NOTE: the buffer registers are reset because inst/inst_pc must read zero
  // straight out of reset; plain storage that nothing observes would not be.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_inst <= '0;
      head_pc   <= '0;
`ifdef FETCH_PREFETCH_EN
      tail_inst <= '0;
      tail_pc   <= '0;
`endif
    end else begin
`ifdef FETCH_PREFETCH_EN
      if (!redirect) begin
        if (pop && count == 2'd2) begin
          head_inst <= tail_inst;
          head_pc   <= tail_pc;
          if (push) begin
            tail_inst <= mem_rdata;
            tail_pc   <= pc;
          end
        end else if (push && (count == 2'd0 || pop)) begin
          head_inst <= mem_rdata;
          head_pc   <= pc;
        end else if (push) begin
          tail_inst <= mem_rdata;
          tail_pc   <= pc;
        end
      end
`else
      // Requests are only issued with the register empty (or emptying).
      if (push) begin
        head_inst <= mem_rdata;
        head_pc   <= pc;
      end
`endif
    end
  end

endmodule

// File: tb/tb_fetch.sv
// -----------------------------------------------------------------------------
// tb_fetch -- directed self-checking bench for fetch (default build, single
// holding register). Memory returns addr ^ 16'hA500, either zero-wait
// (mem_ready follows mem_req) or with a hand-driven mem_ready.
// -----------------------------------------------------------------------------
module tb_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_en;
  logic        redirect;
  logic [15:0] redirect_addr;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ready;
  logic [15:0] mem_rdata;
  logic        inst_valid;
  logic        inst_ready;
  logic [15:0] inst;
  logic [15:0] inst_pc;

  logic zero_wait;
  logic ready_drv;

  int tests = 0;
  int fails = 0;
  logic [31:0] log_q[$];   // {inst, inst_pc} of each handoff to decode

  always #5 clk = ~clk;

  assign mem_ready = zero_wait ? mem_req : ready_drv;
  assign mem_rdata = mem_addr ^ 16'hA500;

  fetch #(.PC_W(16), .RESET_PC(16'h0000)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .fetch_en      (fetch_en),
    .redirect      (redirect),
    .redirect_addr (redirect_addr),
    .mem_req       (mem_req),
    .mem_addr      (mem_addr),
    .mem_ready     (mem_ready),
    .mem_rdata     (mem_rdata),
    .inst_valid    (inst_valid),
    .inst_ready    (inst_ready),
    .inst          (inst),
    .inst_pc       (inst_pc)
  );

  // Handoffs are recorded mid-cycle, before the edge that completes them.
  always @(negedge clk) begin
    if (rst_n && inst_valid && inst_ready) log_q.push_back({inst, inst_pc});
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_handoffs(input string tag, input int n, input int budget);
    int k = 0;
    while (log_q.size() < n && k < budget) begin
      step();
      k++;
    end
    check(tag, (log_q.size() >= n) ? 32'd1 : 32'd0, 32'd1);
  endtask

  task automatic wait_req(input string tag, input logic match_addr,
                          input logic [15:0] addr, input int budget);
    int k = 0;
    while (!(mem_req && (!match_addr || mem_addr == addr)) && k < budget) begin
      step();
      k++;
    end
    check(tag, {31'd0, mem_req}, 32'd1);
  endtask

  task automatic hold_reset();
    rst_n = 1'b0;
    step();
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; fetch_en = 1'b0; redirect = 1'b0; redirect_addr = '0;
    inst_ready = 1'b1; zero_wait = 1'b1; ready_drv = 1'b0;
    step();

    // ---- reset state ----
    check("rst_mem_req",    {31'd0, mem_req},    32'd0);
    check("rst_mem_addr",   {16'd0, mem_addr},   32'd0);
    check("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
    check("rst_inst",       {16'd0, inst},       32'd0);
    check("rst_inst_pc",    {16'd0, inst_pc},    32'd0);

    // ---- zero-wait sequence A500, A501, A502 ----
    log_q.delete();
    rst_n = 1'b1; fetch_en = 1'b1;
    check("seq_idle_before_edge", {31'd0, mem_req}, 32'd0);
    step();
    check("seq_first_req",  {31'd0, mem_req},  32'd1);
    check("seq_first_addr", {16'd0, mem_addr}, 32'd0);
    wait_handoffs("seq_timeout", 3, 30);
    if (log_q.size() >= 3) begin
      check("seq_0", log_q[0], {16'hA500, 16'h0000});
      check("seq_1", log_q[1], {16'hA501, 16'h0001});
      check("seq_2", log_q[2], {16'hA502, 16'h0002});
    end

    // ---- mem_ready delayed 3 cycles ----
    hold_reset();
    zero_wait = 1'b0; ready_drv = 1'b0; inst_ready = 1'b1; fetch_en = 1'b1;
    rst_n = 1'b1;
    step();
    for (int i = 0; i < 3; i++) begin
      check("wait_req",  {31'd0, mem_req},  32'd1);
      check("wait_addr", {16'd0, mem_addr}, 32'd0);
      step();
    end
    ready_drv = 1'b1;
    check("wait_valid_before", {31'd0, inst_valid}, 32'd0);
    step();
    ready_drv = 1'b0;
    check("wait_valid_after", {31'd0, inst_valid}, 32'd1);
    check("wait_inst",        {16'd0, inst},       32'h0000A500);
    check("wait_inst_pc",     {16'd0, inst_pc},    32'd0);

    // ---- back-pressure: buffer full stops requests, no loss on release ----
    hold_reset();
    zero_wait = 1'b1; inst_ready = 1'b0; fetch_en = 1'b1;
    rst_n = 1'b1;
    step();
    step();
    check("bp_full_valid", {31'd0, inst_valid}, 32'd1);
    step(); step(); step();
    check("bp_req_dropped", {31'd0, mem_req}, 32'd0);
    check("bp_head_held",   {16'd0, inst},    32'h0000A500);
    log_q.delete();
    inst_ready = 1'b1;
    wait_handoffs("bp_timeout", 4, 40);
    if (log_q.size() >= 4) begin
      for (int i = 0; i < 4; i++) begin
        logic [15:0] a;
        a = 16'(i);
        check("bp_order", log_q[i], {a ^ 16'hA500, a});
      end
    end

    // ---- redirect while waiting on 0x0005 -> DRAIN ----
    hold_reset();
    zero_wait = 1'b1; inst_ready = 1'b1; fetch_en = 1'b1;
    rst_n = 1'b1;
    wait_req("rd_find_req5", 1'b1, 16'h0005, 40);
    zero_wait = 1'b0; ready_drv = 1'b0;
    redirect = 1'b1; redirect_addr = 16'h0040;
    log_q.delete();
    step();
    redirect = 1'b0;
    check("drain_req",   {31'd0, mem_req},    32'd1);
    check("drain_addr",  {16'd0, mem_addr},   32'h5);
    check("drain_valid", {31'd0, inst_valid}, 32'd0);
    step();
    check("drain_addr_held", {16'd0, mem_addr}, 32'h5);
    ready_drv = 1'b1;
    step();
    ready_drv = 1'b0;
    check("post_drain_req",   {31'd0, mem_req},    32'd1);
    check("post_drain_addr",  {16'd0, mem_addr},   32'h40);
    check("post_drain_valid", {31'd0, inst_valid}, 32'd0);
    zero_wait = 1'b1;
    wait_handoffs("rd_timeout", 1, 20);
    if (log_q.size() >= 1) check("rd_first", log_q[0], {16'hA540, 16'h0040});

    // ---- redirect coincident with mem_ready ----
    wait_req("rc_find_req", 1'b0, 16'h0000, 20);
    redirect = 1'b1; redirect_addr = 16'h0100;
    log_q.delete();
    step();
    redirect = 1'b0;
    check("rc_req",   {31'd0, mem_req},    32'd1);
    check("rc_addr",  {16'd0, mem_addr},   32'h100);
    check("rc_valid", {31'd0, inst_valid}, 32'd0);
    wait_handoffs("rc_timeout", 1, 20);
    if (log_q.size() >= 1) check("rc_first", log_q[0], {16'hA400, 16'h0100});

    // ---- asynchronous reset mid-request ----
    wait_req("ar_find_req", 1'b0, 16'h0000, 20);
    zero_wait = 1'b0; ready_drv = 1'b0;
    step();
    check("ar_pending", {31'd0, mem_req}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("ar_mem_req",    {31'd0, mem_req},    32'd0);
    check("ar_mem_addr",   {16'd0, mem_addr},   32'd0);
    check("ar_inst_valid", {31'd0, inst_valid}, 32'd0);
    check("ar_inst",       {16'd0, inst},       32'd0);
    check("ar_inst_pc",    {16'd0, inst_pc},    32'd0);

    // ---- PC wrap 0xFFFF -> 0x0000 ----
    step();
    zero_wait = 1'b1; inst_ready = 1'b1; fetch_en = 1'b1;
    redirect = 1'b1; redirect_addr = 16'hFFFF;
    rst_n = 1'b1;
    step();
    redirect = 1'b0;
    check("wrap_req",  {31'd0, mem_req},  32'd1);
    check("wrap_addr", {16'd0, mem_addr}, 32'hFFFF);
    step();
    check("wrap_next_addr", {16'd0, mem_addr}, 32'd0);
    check("wrap_inst_pc",   {16'd0, inst_pc},  32'hFFFF);
    check("wrap_inst",      {16'd0, inst},     32'h00005AFF);
    step();
    check("wrap_req0",  {31'd0, mem_req},  32'd1);
    check("wrap_addr0", {16'd0, mem_addr}, 32'd0);

    // ---- fetch_en dropped mid-request: one more instruction, then idle ----
    zero_wait = 1'b0; ready_drv = 1'b0; fetch_en = 1'b0;
    log_q.delete();
    step();
    check("halt_req_held",  {31'd0, mem_req},  32'd1);
    check("halt_addr_held", {16'd0, mem_addr}, 32'd0);
    step();
    ready_drv = 1'b1;
    step();
    ready_drv = 1'b0;
    check("halt_req_off", {31'd0, mem_req}, 32'd0);
    step(); step(); step(); step();
    check("halt_still_off", {31'd0, mem_req},         32'd0);
    check("halt_count",     32'(log_q.size()),        32'd1);
    if (log_q.size() >= 1) check("halt_last", log_q[0], {16'hA500, 16'h0000});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
